// File: rtl/debug_cmd_pkg.sv
// Shared definitions for the debug command arbiter: FSM states, field widths
// and the timeout counter width.
package debug_cmd_pkg;

    localparam int IR_W      = 2;
    localparam int JDO_W_DEF = 38;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/debug_cmd_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, and on contention
// the requester that did not win last time is chosen.
module debug_cmd_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req == 2'b10) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/debug_cmd_arbiter.sv
// Arbitrates two debug command sources onto one CPU debug slave, one
// transaction in flight, with a response timeout that aborts the slave.
//
// state       | meaning
// ST_IDLE     | waiting for any request; winner, ir and jdo latched on exit
// ST_ISSUE    | dn_valid high with the latched command until dn_ready
// ST_WAIT_RSP | waiting for dn_rsp_valid or timeout
// ST_DONE     | one-cycle ack to the granted requester with rsp_data/rsp_err
module debug_cmd_arbiter
    import debug_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          JDO_W          = JDO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [IR_W-1:0]   req_ir0,
    input  logic [IR_W-1:0]   req_ir1,
    input  logic [JDO_W-1:0]  req_jdo0,
    input  logic [JDO_W-1:0]  req_jdo1,
    output logic [1:0]        ack,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [IR_W-1:0]   dn_ir,
    output logic [JDO_W-1:0]  dn_jdo,
    input  logic              dn_rsp_valid,
    input  logic [31:0]       dn_rsp_data,
    output logic              dn_abort,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               grant_q;
    logic               last_grant_q;
    logic               pick;
    logic [IR_W-1:0]    ir_q;
    logic [JDO_W-1:0]   jdo_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               abort_q, abort_d;
    logic               load;
    logic               cap_rsp;
    logic               cap_to;
    logic               timeout;

    debug_cmd_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    // ">=" rather than "==" so a handshake that ties with the limit still
    // times out on the following cycle instead of waiting for a wrap.
    assign timeout = (cnt_q >= TO_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = 1'b0;
        load     = 1'b0;
        cap_rsp  = 1'b0;
        cap_to   = 1'b0;
        dn_valid = 1'b0;
        ack      = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dn_valid = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (dn_ready) begin
                    state_d = ST_WAIT_RSP;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    cap_to  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dn_rsp_valid) begin
                    cap_rsp = 1'b1;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    cap_to  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack     = grant_q ? 2'b10 : 2'b01;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ir_q         <= '0;
            jdo_q        <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            if (load) begin
                grant_q <= pick;
                ir_q    <= pick ? req_ir1 : req_ir0;
                jdo_q   <= pick ? req_jdo1 : req_jdo0;
            end
            if (cap_rsp) begin
                rsp_data_q <= dn_rsp_data;
                rsp_err_q  <= 1'b0;
            end else if (cap_to) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b1;
            end
            if (state_q == ST_DONE) begin
                last_grant_q <= grant_q;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign dn_ir    = ir_q;
    assign dn_jdo   = jdo_q;
    assign dn_abort = abort_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_cmd_arbiter.sv
// Randomized and directed checks of debug_cmd_arbiter against a
// transaction-level model of grant order, latency and timeout outcome.
module tb_debug_cmd_arbiter;

    localparam int TO    = 8;
    localparam int JDO_W = 38;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req = 2'b00;
    logic [1:0]        req_ir0 = '0, req_ir1 = '0;
    logic [JDO_W-1:0]  req_jdo0 = '0, req_jdo1 = '0;
    logic [1:0]        ack;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              dn_valid;
    logic              dn_ready = 1'b0;
    logic [1:0]        dn_ir;
    logic [JDO_W-1:0]  dn_jdo;
    logic              dn_rsp_valid = 1'b0;
    logic [31:0]       dn_rsp_data = '0;
    logic              dn_abort;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int model_last = 1;
    logic [31:0] model_data = '0;

    debug_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .JDO_W(JDO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_ir0      (req_ir0),
        .req_ir1      (req_ir1),
        .req_jdo0     (req_jdo0),
        .req_jdo1     (req_jdo1),
        .ack          (ack),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .dn_valid     (dn_valid),
        .dn_ready     (dn_ready),
        .dn_ir        (dn_ir),
        .dn_jdo       (dn_jdo),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_data  (dn_rsp_data),
        .dn_abort     (dn_abort),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_ack"}, 64'(ack), 0);
        chk({tag, "_dn_valid"}, 64'(dn_valid), 0);
        chk({tag, "_dn_abort"}, 64'(dn_abort), 0);
    endtask

    // Ready is given at relative cycle r (0 = first ISSUE cycle), the response
    // at cycle s. Keep r <= TO-2 for a real handshake, or r >= TO for none.
    task automatic run_txn(input logic [1:0] rq, input int r, input int s, input bit drop,
                           input logic [1:0] i0, input logic [1:0] i1,
                           input logic [JDO_W-1:0] j0, input logic [JDO_W-1:0] j1,
                           input logic [31:0] d);
        int w;
        bit exp_abort;
        int exp_done;
        bit seen;
        logic [1:0] exp_ir;
        logic [JDO_W-1:0] exp_jdo;
        w = (rq == 2'b11) ? (1 - model_last) : (rq[0] ? 0 : 1);
        exp_abort = (r > TO - 1) || (s > TO - 1);
        exp_done  = exp_abort ? TO : s + 1;
        exp_ir    = (w == 1) ? i1 : i0;
        exp_jdo   = (w == 1) ? j1 : j0;
        req_ir0 = i0; req_ir1 = i1; req_jdo0 = j0; req_jdo1 = j1;
        req = rq;
        tick();
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (ack != 2'b00) begin
                seen = 1;
                chk("ack_cycle", 64'(k), 64'(exp_done));
                chk("ack_vec", 64'(ack), (w == 1) ? 64'd2 : 64'd1);
                chk("abort", 64'(dn_abort), 64'(exp_abort));
                chk("rsp_err", 64'(rsp_err), 64'(exp_abort));
                chk("rsp_data", 64'(rsp_data), exp_abort ? 64'd0 : 64'(d));
                model_last = w;
                model_data = exp_abort ? 32'd0 : d;
            end else begin
                chk("dn_valid", 64'(dn_valid), 64'(k <= r));
                chk("busy", 64'(busy), 1);
                chk("abort_early", 64'(dn_abort), 0);
                if (k <= r) begin
                    chk("dn_ir", 64'(dn_ir), 64'(exp_ir));
                    chk("dn_jdo", 64'(dn_jdo), 64'(exp_jdo));
                end
                dn_ready     = (k == r);
                dn_rsp_valid = (k == s);
                dn_rsp_data  = (k == s) ? d : $urandom();
                if (drop && k == 1) req = 2'b00;
                tick();
            end
        end
        chk("ack_seen", 64'(seen), 1);
        dn_ready = 1'b0;
        dn_rsp_valid = 1'b0;
        tick();
        chk_idle("post_done");
        req = 2'b00;
    endtask

    initial begin
        int r, s;
        reset = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_rsp_data", 64'(rsp_data), 0);
        chk("reset_rsp_err", 64'(rsp_err), 0);
        reset = 1'b0;
        tick();

        // single request, ready same cycle, response two cycles later
        run_txn(2'b01, 0, 2, 0, 2'b10, 2'b01, 38'h15, 38'h2A, 32'hDEADBEEF);

        // stray response while idle
        dn_rsp_valid = 1'b1;
        dn_rsp_data  = $urandom();
        tick();
        dn_rsp_valid = 1'b0;
        chk_idle("stray");
        chk("stray_rsp_data", 64'(rsp_data), 64'(model_data));
        tick();
        chk_idle("stray2");

        // reset while waiting for the response
        req = 2'b01;
        tick();
        dn_ready = 1'b1;
        tick();
        dn_ready = 1'b0;
        req = 2'b00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last = 1;
        model_data = '0;
        chk_idle("mid_reset");
        chk("mid_reset_rsp_data", 64'(rsp_data), 0);
        chk("mid_reset_rsp_err", 64'(rsp_err), 0);

        // contention, back to back
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, 0, 1, 0, 2'(i), 2'(i + 1), 38'(i * 7), 38'(i * 11), $urandom());

        // timeout with no ready, then tie at the last count
        run_txn(2'b10, 100, 200, 0, 2'b11, 2'b01, 38'h3, 38'h1F, $urandom());
        run_txn(2'b01, 3, 7, 0, 2'b00, 2'b10, 38'h77, 38'h5, 32'hCAFE0001);
        run_txn(2'b11, 2, 8, 0, 2'b01, 2'b10, 38'h1, 38'h2, $urandom());
        // requester drops req mid-transaction
        run_txn(2'b10, 1, 4, 1, 2'b11, 2'b00, 38'h9, 38'hA, $urandom());

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 100;
                s = 200;
            end else begin
                r = $urandom_range(0, TO - 2);
                s = r + 1 + $urandom_range(0, 4);
            end
            run_txn(2'($urandom_range(1, 3)), r, s, 1'($urandom_range(0, 3) == 0),
                    2'($urandom()), 2'($urandom()),
                    38'({$urandom(), $urandom()}), 38'({$urandom(), $urandom()}),
                    $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
